// File: rtl/h264_enc_pkg.sv
// Shared types and default widths for the ece751 H.264 encoder control blocks.
package h264_enc_pkg;

    localparam int DEF_MB_W_BITS = 8;
    localparam int DEF_MB_H_BITS = 8;
    localparam int DEF_QP_BITS   = 6;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 3'd0;
    localparam sched_state_t ST_ISSUE = 3'd1;
    localparam sched_state_t ST_WAIT  = 3'd2;
    localparam sched_state_t ST_DRAIN = 3'd3;
    localparam sched_state_t ST_DONE  = 3'd4;

    // Payload carried alongside mb_req towards the encoder core.
    typedef struct packed {
        logic [DEF_MB_W_BITS-1:0] x;
        logic [DEF_MB_H_BITS-1:0] y;
        logic [DEF_QP_BITS-1:0]   qp;
        logic                     last;
    } mb_payload_t;

endpackage

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock position counter with last-macroblock detection.
module mb_raster_counter #(
    parameter int MB_W_BITS = 8,
    parameter int MB_H_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    input  logic [MB_W_BITS-1:0] cols,
    input  logic [MB_H_BITS-1:0] rows,
    output logic [MB_W_BITS-1:0] x,
    output logic [MB_H_BITS-1:0] y,
    output logic                 last
);

    logic [MB_W_BITS-1:0] x_max;
    logic [MB_H_BITS-1:0] y_max;

    assign x_max = cols - MB_W_BITS'(1);
    assign y_max = rows - MB_H_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x == x_max) begin
                x <= '0;
                y <= y + MB_H_BITS'(1);
            end else begin
                x <= x + MB_W_BITS'(1);
            end
        end
    end

    // cols/rows reset to zero, so x_max/y_max are all-ones and last stays low.
    assign last = (x == x_max) && (y == y_max);

endmodule

// File: rtl/h264_mb_scheduler.sv
// Frame-level macroblock scheduler: issues macroblocks in raster order to the
// encoder core and reports busy / error / frame-done status.
module h264_mb_scheduler
    import h264_enc_pkg::*;
#(
    parameter int MB_W_BITS = DEF_MB_W_BITS,
    parameter int MB_H_BITS = DEF_MB_H_BITS,
    parameter int QP_BITS   = DEF_QP_BITS
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic [MB_W_BITS-1:0] cfg_mb_cols,
    input  logic [MB_H_BITS-1:0] cfg_mb_rows,
    input  logic [QP_BITS-1:0]   cfg_qp,
    output logic                 mb_req,
    input  logic                 mb_ack,
    output logic [MB_W_BITS-1:0] mb_x,
    output logic [MB_H_BITS-1:0] mb_y,
    output logic [QP_BITS-1:0]   mb_qp,
    output logic                 mb_last,
    input  logic                 mb_done,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err,
    output logic [15:0]          mb_count
);

    sched_state_t         state;
    sched_state_t         state_next;
    logic [MB_W_BITS-1:0] cols_q;
    logic [MB_H_BITS-1:0] rows_q;
    logic [QP_BITS-1:0]   qp_q;
    logic                 accept;
    logic                 clr;
    logic                 adv;
    logic                 cnt_inc;
    logic                 err_set;

    mb_raster_counter #(
        .MB_W_BITS(MB_W_BITS),
        .MB_H_BITS(MB_H_BITS)
    ) u_counter (
        .clk  (ACLK),
        .rst_n(ARESETN),
        .clr  (clr),
        .adv  (adv),
        .cols (cols_q),
        .rows (rows_q),
        .x    (mb_x),
        .y    (mb_y),
        .last (mb_last)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clr        = 1'b0;
        adv        = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    if ((cfg_mb_cols != '0) && (cfg_mb_rows != '0)) begin
                        accept     = 1'b1;
                        clr        = 1'b1;
                        state_next = ST_ISSUE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // An abort wins over a coincident handshake, which is dropped.
                if (cfg_abort) begin
                    state_next = ST_IDLE;
                end else if (mb_ack) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mb_done) begin
                    cnt_inc = 1'b1;
                    if (cfg_abort) begin
                        state_next = ST_IDLE;
                    end else if (mb_last) begin
                        state_next = ST_DONE;
                    end else begin
                        adv        = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end else if (cfg_abort) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mb_done) begin
                    cnt_inc    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (mb_done && (state != ST_WAIT) && (state != ST_DRAIN)) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= ST_IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            qp_q     <= '0;
            mb_count <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cols_q   <= cfg_mb_cols;
                rows_q   <= cfg_mb_rows;
                qp_q     <= cfg_qp;
                mb_count <= '0;
            end else if (cnt_inc) begin
                mb_count <= mb_count + 16'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (accept) begin
                err <= 1'b0;
            end
        end
    end

    assign mb_req     = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);
    assign mb_qp      = qp_q;

endmodule

// File: tb/tb_h264_mb_scheduler.sv
// Directed bench for h264_mb_scheduler: frames, stalls, errors, aborts and reset.
module tb_h264_mb_scheduler;

    logic        ACLK;
    logic        ARESETN;
    logic        cfg_start;
    logic        cfg_abort;
    logic [7:0]  cfg_mb_cols;
    logic [7:0]  cfg_mb_rows;
    logic [5:0]  cfg_qp;
    logic        mb_req;
    logic        mb_ack;
    logic [7:0]  mb_x;
    logic [7:0]  mb_y;
    logic [5:0]  mb_qp;
    logic        mb_last;
    logic        mb_done;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [15:0] mb_count;

    int vectors;
    int miscompares;

    h264_mb_scheduler dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_mb_cols(cfg_mb_cols),
        .cfg_mb_rows(cfg_mb_rows),
        .cfg_qp     (cfg_qp),
        .mb_req     (mb_req),
        .mb_ack     (mb_ack),
        .mb_x       (mb_x),
        .mb_y       (mb_y),
        .mb_qp      (mb_qp),
        .mb_last    (mb_last),
        .mb_done    (mb_done),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .mb_count   (mb_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort, input logic [7:0] cols,
                                 input logic [7:0] rows, input logic [5:0] qp);
        cfg_start   = start;
        cfg_abort   = abort;
        cfg_mb_cols = cols;
        cfg_mb_rows = rows;
        cfg_qp      = qp;
        step();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
    endtask

    // Entered with the DUT presenting a request; leaves one cycle after mb_done.
    task automatic serviceRequest(input logic [7:0] ex, input logic [7:0] ey, input logic el,
                                  input logic [5:0] eq, input int stall, input logic ack_after,
                                  input int done_delay);
        for (int i = 0; i < stall; i++) begin
            mb_ack = 1'b0;
            checkOutput("stall_req", mb_req, 1);
            checkOutput("stall_x", mb_x, ex);
            checkOutput("stall_y", mb_y, ey);
            checkOutput("stall_last", mb_last, el);
            checkOutput("stall_qp", mb_qp, eq);
            step();
        end
        mb_ack = 1'b1;
        checkOutput("req", mb_req, 1);
        checkOutput("req_x", mb_x, ex);
        checkOutput("req_y", mb_y, ey);
        checkOutput("req_last", mb_last, el);
        checkOutput("req_qp", mb_qp, eq);
        step();
        mb_ack = ack_after;
        checkOutput("wait_req", mb_req, 0);
        for (int i = 1; i < done_delay; i++) step();
        mb_done = 1'b1;
        step();
        mb_done = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ARESETN     = 1'b0;
        cfg_start   = 1'b0;
        cfg_abort   = 1'b0;
        cfg_mb_cols = 8'd0;
        cfg_mb_rows = 8'd0;
        cfg_qp      = 6'd0;
        mb_ack      = 1'b0;
        mb_done     = 1'b0;
        step();
        step();
        ARESETN = 1'b1;
        step();

        $display("[TB] reset state");
        checkOutput("rst_req", mb_req, 0);
        checkOutput("rst_x", mb_x, 0);
        checkOutput("rst_y", mb_y, 0);
        checkOutput("rst_qp", mb_qp, 0);
        checkOutput("rst_last", mb_last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_fdone", frame_done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_count", mb_count, 0);

        $display("[TB] 2x2 frame, ack tied high");
        mb_ack = 1'b1;
        applyStimulus(1, 0, 8'd2, 8'd2, 6'd26);
        checkOutput("f1_busy", busy, 1);
        serviceRequest(8'd0, 8'd0, 0, 6'd26, 0, 1, 3);
        checkOutput("f1_count1", mb_count, 1);
        serviceRequest(8'd1, 8'd0, 0, 6'd26, 0, 1, 3);
        checkOutput("f1_count2", mb_count, 2);
        serviceRequest(8'd0, 8'd1, 0, 6'd26, 0, 1, 3);
        checkOutput("f1_count3", mb_count, 3);
        checkOutput("f1_nofdone", frame_done, 0);
        serviceRequest(8'd1, 8'd1, 1, 6'd26, 0, 1, 3);
        checkOutput("f1_fdone", frame_done, 1);
        checkOutput("f1_count4", mb_count, 4);
        checkOutput("f1_busy_done", busy, 1);
        step();
        checkOutput("f1_fdone_off", frame_done, 0);
        checkOutput("f1_idle", busy, 0);
        checkOutput("f1_err", err, 0);
        checkOutput("f1_count_hold", mb_count, 4);

        $display("[TB] 3x1 frame, ack stalled 5 cycles");
        mb_ack = 1'b0;
        applyStimulus(1, 0, 8'd3, 8'd1, 6'd12);
        checkOutput("f2_count_clr", mb_count, 0);
        serviceRequest(8'd0, 8'd0, 0, 6'd12, 5, 0, 2);
        serviceRequest(8'd1, 8'd0, 0, 6'd12, 5, 0, 2);
        serviceRequest(8'd2, 8'd0, 1, 6'd12, 5, 0, 2);
        checkOutput("f2_fdone", frame_done, 1);
        checkOutput("f2_count", mb_count, 3);
        step();
        checkOutput("f2_idle", busy, 0);

        $display("[TB] zero-dimension start, then 1x1");
        applyStimulus(1, 0, 8'd0, 8'd2, 6'd3);
        checkOutput("z_err", err, 1);
        checkOutput("z_busy", busy, 0);
        checkOutput("z_req", mb_req, 0);
        step();
        checkOutput("z_busy2", busy, 0);
        checkOutput("z_req2", mb_req, 0);
        checkOutput("z_err2", err, 1);
        applyStimulus(1, 0, 8'd1, 8'd1, 6'd40);
        checkOutput("one_err_clr", err, 0);
        checkOutput("one_req", mb_req, 1);
        serviceRequest(8'd0, 8'd0, 1, 6'd40, 0, 0, 1);
        checkOutput("one_fdone", frame_done, 1);
        checkOutput("one_count", mb_count, 1);
        step();

        $display("[TB] abort in WAIT");
        mb_ack = 1'b1;
        applyStimulus(1, 0, 8'd2, 8'd2, 6'd7);
        step();
        mb_ack = 1'b0;
        checkOutput("aw_wait_req", mb_req, 0);
        applyStimulus(0, 1, 8'd2, 8'd2, 6'd7);
        checkOutput("aw_drain_busy", busy, 1);
        checkOutput("aw_drain_req", mb_req, 0);
        step();
        checkOutput("aw_drain_busy2", busy, 1);
        checkOutput("aw_drain_fdone", frame_done, 0);
        mb_done = 1'b1;
        step();
        mb_done = 1'b0;
        checkOutput("aw_idle", busy, 0);
        checkOutput("aw_count", mb_count, 1);
        checkOutput("aw_fdone", frame_done, 0);
        checkOutput("aw_err", err, 0);
        step();
        checkOutput("aw_fdone2", frame_done, 0);

        $display("[TB] abort in ISSUE with coincident ack");
        mb_ack = 1'b0;
        applyStimulus(1, 0, 8'd2, 8'd2, 6'd7);
        checkOutput("ai_req", mb_req, 1);
        mb_ack = 1'b1;
        applyStimulus(0, 1, 8'd2, 8'd2, 6'd7);
        mb_ack = 1'b0;
        checkOutput("ai_idle", busy, 0);
        checkOutput("ai_req_off", mb_req, 0);
        checkOutput("ai_count", mb_count, 0);
        step();
        checkOutput("ai_idle2", busy, 0);
        checkOutput("ai_fdone", frame_done, 0);

        $display("[TB] stray mb_done, start while busy");
        mb_done = 1'b1;
        step();
        mb_done = 1'b0;
        checkOutput("stray_err", err, 1);
        checkOutput("stray_busy", busy, 0);
        mb_ack = 1'b1;
        applyStimulus(1, 0, 8'd2, 8'd1, 6'd20);
        checkOutput("bs_err_clr", err, 0);
        checkOutput("bs_req", mb_req, 1);
        step();
        applyStimulus(1, 0, 8'd1, 8'd1, 6'd10);
        checkOutput("bs_ign_busy", busy, 1);
        checkOutput("bs_ign_req", mb_req, 0);
        mb_done = 1'b1;
        step();
        mb_done = 1'b0;
        checkOutput("bs_count1", mb_count, 1);
        serviceRequest(8'd1, 8'd0, 1, 6'd20, 0, 1, 3);
        checkOutput("bs_fdone", frame_done, 1);
        checkOutput("bs_count2", mb_count, 2);
        checkOutput("bs_err", err, 0);
        step();

        $display("[TB] reset mid-WAIT");
        applyStimulus(1, 0, 8'd2, 8'd1, 6'd33);
        serviceRequest(8'd0, 8'd0, 0, 6'd33, 0, 1, 3);
        step();
        checkOutput("mr_wait_last", mb_last, 1);
        ARESETN = 1'b0;
        #2;
        checkOutput("mr_req", mb_req, 0);
        checkOutput("mr_x", mb_x, 0);
        checkOutput("mr_y", mb_y, 0);
        checkOutput("mr_qp", mb_qp, 0);
        checkOutput("mr_last", mb_last, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_fdone", frame_done, 0);
        checkOutput("mr_err", err, 0);
        checkOutput("mr_count", mb_count, 0);
        ARESETN = 1'b1;
        step();
        applyStimulus(1, 0, 8'd1, 8'd1, 6'd5);
        checkOutput("mr_new_busy", busy, 1);
        serviceRequest(8'd0, 8'd0, 1, 6'd5, 0, 0, 2);
        checkOutput("mr_new_fdone", frame_done, 1);
        checkOutput("mr_new_count", mb_count, 1);
        step();
        checkOutput("mr_new_idle", busy, 0);
        checkOutput("mr_new_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/h264_mb_scheduler.md
# h264_mb_scheduler

Macroblock scheduler for the ece751 H.264 encoder. Latches frame geometry and QP from the AXI4-Lite register file on a start command. Walks the frame in raster order, issuing one macroblock at a time to the encoder core over a valid/ready request channel, and waits for the core's completion pulse before issuing the next. Reports busy, error and frame-done status back to the register file.

## Interface
- MB_W_BITS, 8, width of the macroblock column index and column count
- MB_H_BITS, 8, width of the macroblock row index and row count
- QP_BITS, 6, quantiser parameter width
- ACLK  in  1  clock; all logic is on the rising edge
- ARESETN  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse: start a frame
- cfg_abort  in  1  one-cycle pulse: abort the current frame
- cfg_mb_cols  in  MB_W_BITS  frame width in macroblocks
- cfg_mb_rows  in  MB_H_BITS  frame height in macroblocks
- cfg_qp  in  QP_BITS  QP applied to every macroblock of the frame
- mb_req  out  1  request valid
- mb_ack  in  1  request ready; the handshake completes when mb_req and mb_ack are both 1
- mb_x  out  MB_W_BITS  column of the requested macroblock
- mb_y  out  MB_H_BITS  row of the requested macroblock
- mb_qp  out  QP_BITS  latched QP
- mb_last  out  1  the requested macroblock is the last one of the frame
- mb_done  in  1  one-cycle pulse from the core: current macroblock finished
- busy  out  1  high whenever the block is not in IDLE
- frame_done  out  1  one-cycle pulse when a frame completes normally
- err  out  1  sticky error flag
- mb_count  out  16  number of macroblocks completed in the current or last frame

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - On cfg_start with cfg_mb_cols≠0 and cfg_mb_rows≠0: latch cols, rows and qp; clear x, y, mb_count and err; go to ISSUE.
  - On cfg_start with either dimension zero: set err and stay in IDLE.
- ISSUE: hold mb_req=1 with stable mb_x, mb_y, mb_qp and mb_last until mb_ack. On the handshake, go to WAIT.
- WAIT: mb_req=0. On mb_done, increment mb_count.
  - If mb_last: go to DONE.
  - Otherwise advance the position and go to ISSUE. Advance rule: x+1; when x = cols−1, wrap x to 0 and do y+1.
- DONE: frame_done=1 for exactly this one cycle, then go to IDLE.
- Abort:
  - In ISSUE, with or without a coincident mb_ack: go to IDLE. A handshake completing in that same cycle is discarded.
  - In WAIT: go to DRAIN.
  - In DRAIN: wait for mb_done, increment mb_count, go to IDLE. frame_done is never asserted after an abort.
  - In IDLE or DONE: ignored.
- cfg_start outside IDLE: ignored. cfg_* inputs are not re-sampled mid-frame.
- mb_done outside WAIT and DRAIN: set err and otherwise ignore it.
- err is cleared only by an accepted cfg_start.
- mb_last = (x = cols−1) && (y = rows−1). With cols=rows=1, the first macroblock has mb_last=1.

## Timing
- Reset values: IDLE; mb_req=0; mb_x=0; mb_y=0; mb_qp=0; mb_last=0; busy=0; frame_done=0; err=0; mb_count=0.
- cfg_start sampled at cycle N → busy=1 and mb_req=1 at N+1.
- mb_ack may be high before mb_req. If mb_ack is already high when mb_req rises, the handshake completes in the first request cycle, and mb_req=0 from the next cycle.
- mb_done at cycle M, not last → the next mb_req=1 at M+1, with the updated x and y registered. There is one idle cycle on the request channel per macroblock by design.
- mb_done at cycle M, last → frame_done=1 at M+1; busy=0 and IDLE at M+2.
- All outputs are registered. There is no combinational path from any input to any output.
- mb_count is registered and does not wrap: 255×255 = 65025 < 2^16.

## Structure
- Shared package h264_enc_pkg holds:
  - the state enum (sched_state_t)
  - MB_W_BITS, MB_H_BITS and QP_BITS defaults
  - the mb_req payload struct (x, y, qp, last)
- Sub-module mb_raster_counter owns the x/y registers, the wrap logic and the mb_last compare. Its inputs are clr, adv, cols and rows.
- The scheduler FSM instantiates the counter once.

## Test plan
- 2×2 frame, mb_ack tied to 1, mb_done 3 cycles after each ack:
  - requests at (0,0), (1,0), (0,1), (1,1); mb_last only on (1,1)
  - frame_done exactly 1 cycle; mb_count=4; err=0
- 3×1 frame, mb_ack held low 5 cycles per request: mb_req and the payload stay stable throughout each stall; x wraps correctly; frame completes with mb_count=3.
- Start with cols=0: err=1, busy stays 0, no mb_req. A following valid 1×1 start clears err and shows mb_last on the first request.
- Abort cases:
  - abort in WAIT → DRAIN until mb_done → IDLE, no frame_done, mb_count=1
  - abort in ISSUE → IDLE next cycle, mb_count=0
- Stray mb_done in IDLE → err=1. cfg_start while busy → ignored; the frame continues unchanged.
- ARESETN asserted mid-WAIT → all outputs return to their reset values immediately; a new start after reset runs a clean 1×1 frame.
